wave_ram_loader: RTL and testbench
==================================

WAVE_RAM_LOADER -- requirements
Module: wave_ram_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, giving the waveform table depth of 2**ADDR_WIDTH entries.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the sample width.
REQ-003 Port: clk  input  1  rising-edge clock for all logic.
REQ-004 Port: tb_rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: start  input  1  single-cycle request to begin a load.
REQ-006 Port: abort  input  1  cancels any operation in progress.
REQ-007 Port: s_data  input  DATA_WIDTH  incoming sample.
REQ-008 Port: s_valid  input  1  s_data is valid.
REQ-009 Port: s_ready  output  1  the loader accepts a sample this cycle.
REQ-010 Port: ram_wr_en  output  1  RAM write strobe.
REQ-011 Port: ram_wr_addr  output  ADDR_WIDTH  RAM write address.
REQ-012 Port: ram_wr_data  output  DATA_WIDTH  RAM write data.
REQ-013 Port: ram_rd_addr  output  ADDR_WIDTH  RAM read address.
REQ-014 Port: ram_rd_data  input  DATA_WIDTH  RAM read data; valid exactly 1 cycle after ram_rd_addr is presented (unregistered output stage).
REQ-015 Port: busy  output  1  high in the WRITE and VERIFY states.
REQ-016 Port: done  output  1  load and verify have completed.
REQ-017 Port: error  output  1  the readback checksum mismatched.

Function
REQ-018 The state machine SHALL have the states IDLE, WRITE, VERIFY and DONE.
REQ-019 In IDLE or DONE, start SHALL clear the write index, both checksums, done and error, and move to WRITE on the next edge.
REQ-020 start SHALL be ignored in WRITE and in VERIFY.
REQ-021 In WRITE, s_ready SHALL be 1 while the write index is at most 2**ADDR_WIDTH-1, and 0 in every other state.
REQ-022 A handshake occurs when s_valid and s_ready are both 1 at a rising edge.
REQ-023 For a handshake at edge N, ram_wr_en SHALL be 1 from edge N for one cycle, with ram_wr_addr = index and ram_wr_data = s_data; the write index SHALL then increment.
REQ-024 With no handshake, ram_wr_en SHALL be 0; gaps in s_valid SHALL stall the loader without losing data.
REQ-025 Each accepted sample SHALL be added, zero-extended, into a write checksum sum_wr of width DATA_WIDTH+ADDR_WIDTH, which cannot overflow.
REQ-026 After the handshake for index 2**ADDR_WIDTH-1, s_ready SHALL drop immediately (next cycle) and the state SHALL become VERIFY one cycle after the final ram_wr_en, so that no read overlaps a write.
REQ-027 In VERIFY, ram_rd_addr SHALL step from 0 to 2**ADDR_WIDTH-1, one address per cycle.
REQ-028 In VERIFY, ram_rd_data SHALL be accumulated into sum_rd one cycle after each address, giving exactly 2**ADDR_WIDTH samples.
REQ-029 After the last sample is accumulated, the state SHALL become DONE with done=1 and error=(sum_wr != sum_rd).
REQ-030 done and error SHALL be registered and SHALL hold until the next start, abort or reset.
REQ-031 abort in any state SHALL force IDLE on the next edge, clear done, error, ram_wr_en and s_ready, and suppress any pending write.
REQ-032 If start and abort are asserted together, abort SHALL win.
REQ-033 ram_rd_addr SHALL stay at 0 outside VERIFY.
REQ-034 The write index SHALL be ADDR_WIDTH+1 bits wide, so that table-full is detected without wrap-around.

Reset
REQ-035 On tb_rst assertion, the block SHALL asynchronously enter IDLE with s_ready=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_rd_addr=0, busy=0, done=0 and error=0, and with the index and both checksums cleared.
REQ-036 tb_rst asserted mid-WRITE or mid-VERIFY SHALL abandon the operation, and no write strobe SHALL occur while reset is high.

Verification
REQ-037 Pulse start, then stream bytes i mod 256 for i=0..2047 with s_valid held high, against a 2048x8 RAM model -> 2048 writes at consecutive addresses; sum = 8*32640 = 261120; done=1, error=0.
REQ-038 Repeat the stream with s_valid toggling in a random pattern -> the same RAM contents, done=1, error=0, and no duplicated or skipped addresses.
REQ-039 Have the RAM model corrupt address 5 on readback by XOR 0x01 -> done=1, error=1.
REQ-040 Assert abort after the 100th handshake -> the next cycle shows s_ready=0, busy=0 and no further ram_wr_en; a following start reloads from address 0.
REQ-041 Pulse start in the middle of WRITE and in the middle of VERIFY -> no effect on the index or the state; assert start and abort together -> IDLE.
REQ-042 Assert tb_rst for 3 cycles during VERIFY -> all outputs are immediately at their reset values; a subsequent full load completes with error=0.

Source files
------------

// File: rtl/wave_ram_loader_if.sv
// Sample-stream and waveform-RAM bus for wave_ram_loader.
//   s_data/s_valid/s_ready : incoming sample stream (valid/ready handshake)
//   ram_wr_en/addr/data    : RAM write port
//   ram_rd_addr/ram_rd_data: RAM read port, data valid one cycle after address
// master: the loader side. slave: the stream source / RAM side.
interface wave_ram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    input  s_data, s_valid, ram_rd_data,
    output s_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport slave (
    output s_data, s_valid, ram_rd_data,
    input  s_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );
endinterface

// File: rtl/wave_ram_loader.sv
// Waveform RAM loader: on start, accepts 2**ADDR_WIDTH samples from a valid/ready stream,
// writes them to consecutive RAM addresses while summing them, then reads the whole table
// back, sums the readback and flags a checksum mismatch.
//   clk    : rising-edge clock
//   tb_rst : asynchronous active-high reset
//   start  : one-cycle load request (honoured in IDLE/DONE only)
//   abort  : cancel, return to IDLE (wins over start)
//   bus    : stream + RAM bus (wave_ram_loader_if.master)
//   busy   : high in WRITE and VERIFY
//   done   : load and verify complete (held until start/abort/reset)
//   error  : readback checksum differed from write checksum
module wave_ram_loader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 tb_rst,
  input  logic                 start,
  input  logic                 abort,
  wave_ram_loader_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned SumWidth = DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWrite, StVerify, StDone} state_e;

  state_e                state_q, state_d;
  // One extra bit so a full table reads as index == 2**ADDR_WIDTH instead of wrapping.
  logic [ADDR_WIDTH:0]   wr_idx_q, wr_idx_d;
  logic [ADDR_WIDTH:0]   rd_idx_q, rd_idx_d;
  // An address was presented last cycle, so ram_rd_data is valid now.
  logic                  rd_pend_q, rd_pend_d;
  logic [SumWidth-1:0]   sum_wr_q, sum_wr_d;
  logic [SumWidth-1:0]   sum_rd_q, sum_rd_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  handshake;

  assign bus.s_ready     = (state_q == StWrite) && !wr_idx_q[ADDR_WIDTH];
  assign handshake       = bus.s_valid && bus.s_ready;
  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign bus.ram_rd_addr = (state_q == StVerify) ? rd_idx_q[ADDR_WIDTH-1:0] : '0;
  assign busy            = (state_q == StWrite) || (state_q == StVerify);
  assign done            = done_q;
  assign error           = error_q;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    rd_pend_d = 1'b0;
    sum_wr_d  = sum_wr_q;
    sum_rd_d  = sum_rd_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    error_d   = error_q;

    if (abort) begin
      // Any handshake in this cycle is dropped: wr_en_d stays low.
      state_d  = StIdle;
      rd_idx_d = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d  = StWrite;
            wr_idx_d = '0;
            rd_idx_d = '0;
            sum_wr_d = '0;
            sum_rd_d = '0;
            done_d   = 1'b0;
            error_d  = 1'b0;
          end
        end
        StWrite: begin
          if (handshake) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_idx_q[ADDR_WIDTH-1:0];
            wr_data_d = bus.s_data;
            wr_idx_d  = wr_idx_q + 1'b1;
            sum_wr_d  = sum_wr_q + SumWidth'(bus.s_data);
          end else if (wr_idx_q[ADDR_WIDTH]) begin
            // Reached one cycle after the final write strobe, so reads never overlap writes.
            state_d  = StVerify;
            rd_idx_d = '0;
          end
        end
        StVerify: begin
          if (!rd_idx_q[ADDR_WIDTH]) begin
            rd_idx_d  = rd_idx_q + 1'b1;
            rd_pend_d = 1'b1;
          end
          if (rd_pend_q) begin
            sum_rd_d = sum_rd_q + SumWidth'(bus.ram_rd_data);
            // All addresses issued and this is the last pending sample.
            if (rd_idx_q[ADDR_WIDTH]) begin
              state_d = StDone;
              done_d  = 1'b1;
              error_d = (sum_wr_q != sum_rd_d);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q   <= StIdle;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      rd_pend_q <= 1'b0;
      sum_wr_q  <= '0;
      sum_rd_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      rd_pend_q <= rd_pend_d;
      sum_wr_q  <= sum_wr_d;
      sum_rd_q  <= sum_rd_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_wave_ram_loader.sv
// Self-checking bench for wave_ram_loader: table of full-load scenarios plus hand-written
// abort, start/abort priority and mid-verify reset sequences, against a 2048x8 RAM model.
module tb_wave_ram_loader;

  localparam int unsigned Depth  = 2048;
  localparam int unsigned ExpSum = 261120;

  logic clk;
  logic tb_rst;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic error;
  logic corrupt;

  int unsigned checks;
  int unsigned errors;
  int unsigned wr_total;
  int unsigned wr_base;
  int unsigned seq_err;

  wave_ram_loader_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

  wave_ram_loader #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) dut (
    .clk    (clk),
    .tb_rst (tb_rst),
    .start  (start),
    .abort  (abort),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read (data one cycle after address).
  logic [7:0] mem [Depth];
  logic [7:0] rd_q;
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    rd_q <= mem[bus.ram_rd_addr] ^ ((corrupt && bus.ram_rd_addr == 11'd5) ? 8'h01 : 8'h00);
  end
  assign bus.ram_rd_data = rd_q;

  // Write monitor: every strobe must hit the next consecutive address with data addr mod 256,
  // and no strobe may appear while reset is high.
  initial begin
    wr_total = 0;
    seq_err  = 0;
  end
  always @(negedge clk) begin
    if (bus.ram_wr_en) begin
      if (tb_rst || bus.ram_wr_addr != 11'(wr_total - wr_base) ||
          bus.ram_wr_data != bus.ram_wr_addr[7:0]) seq_err++;
      wr_total++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stream samples i mod 256 until n handshakes have happened.
  task automatic stream(input bit rnd, input bit poke, input int n);
    int  i;
    int  guard;
    bit  acc;
    bit  poked;
    i = 0; guard = 0; poked = 1'b0;
    while (i < n && guard < 20000) begin
      @(negedge clk);
      bus.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = 8'(i);
      if (poke && !poked && i == 700) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
    end
  endtask

  task automatic run_load(input bit rnd, input bit poke, input bit exp_err, input string tag);
    int unsigned base;
    int unsigned sbase;
    int unsigned sum;
    int          guard;
    base    = wr_total;
    sbase   = seq_err;
    wr_base = wr_total;
    pulse_start();
    stream(rnd, poke, Depth);
    @(negedge clk);
    bus.s_valid = 1'b0;
    start       = 1'b0;
    check({tag, "_ready_drop"}, 32'(bus.s_ready), 0);
    if (poke) begin
      repeat (300) @(negedge clk);
      check({tag, "_busy_mid_verify"}, 32'(busy), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    sum = 0;
    for (int a = 0; a < Depth; a++) sum += 32'(mem[a]);
    check({tag, "_done"},    32'(done), 1);
    check({tag, "_error"},   32'(error), 32'(exp_err));
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_writes"},  wr_total - base, Depth);
    check({tag, "_seq"},     seq_err - sbase, 0);
    check({tag, "_ram_sum"}, sum, ExpSum);
    check({tag, "_rd_addr"}, 32'(bus.ram_rd_addr), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},  32'(bus.s_ready), 0);
    check({tag, "_wr_en"},    32'(bus.ram_wr_en), 0);
    check({tag, "_wr_addr"},  32'(bus.ram_wr_addr), 0);
    check({tag, "_wr_data"},  32'(bus.ram_wr_data), 0);
    check({tag, "_rd_addr"},  32'(bus.ram_rd_addr), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_error"},    32'(error), 0);
  endtask

  typedef struct {
    bit rnd;
    bit corrupt;
    bit poke;
    bit exp_error;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int unsigned base;
    vecs[0] = '{rnd: 1'b0, corrupt: 1'b0, poke: 1'b0, exp_error: 1'b0};
    vecs[1] = '{rnd: 1'b1, corrupt: 1'b0, poke: 1'b0, exp_error: 1'b0};
    vecs[2] = '{rnd: 1'b1, corrupt: 1'b0, poke: 1'b1, exp_error: 1'b0};
    vecs[3] = '{rnd: 1'b0, corrupt: 1'b1, poke: 1'b0, exp_error: 1'b1};

    checks      = 0;
    errors      = 0;
    wr_base     = 0;
    tb_rst      = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    corrupt     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    tb_rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      corrupt = vecs[k].corrupt;
      run_load(vecs[k].rnd, vecs[k].poke, vecs[k].exp_error, $sformatf("vec%0d", k));
      corrupt = 1'b0;
    end

    // From DONE with error=1: start and abort together must land in IDLE and clear flags.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("both_busy",  32'(busy), 0);
    check("both_done",  32'(done), 0);
    check("both_error", 32'(error), 0);
    @(negedge clk);
    check("both_stay_idle", 32'(busy), 0);

    // Abort after the 100th handshake.
    base    = wr_total;
    wr_base = wr_total;
    pulse_start();
    stream(1'b0, 1'b0, 100);
    @(negedge clk);
    check("abort_last_wr_en", 32'(bus.ram_wr_en), 1);
    abort       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd100;
    @(negedge clk);
    abort = 1'b0;
    check("abort_s_ready", 32'(bus.s_ready), 0);
    check("abort_busy",    32'(busy), 0);
    check("abort_wr_en",   32'(bus.ram_wr_en), 0);
    repeat (5) @(negedge clk);
    bus.s_valid = 1'b0;
    check("abort_writes", wr_total - base, 100);
    run_load(1'b0, 1'b0, 1'b0, "reload");

    // Reset for 3 cycles in the middle of VERIFY.
    wr_base = wr_total;
    pulse_start();
    stream(1'b0, 1'b0, Depth);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (500) @(negedge clk);
    check("mid_verify_busy",    32'(busy), 1);
    check("mid_verify_rd_addr", 32'(bus.ram_rd_addr != 11'd0), 1);
    #2;
    tb_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_rst = 1'b0;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_done", 32'(done), 0);
    run_load(1'b1, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
